// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller state encoding, round/key sizing and the Rcon table.
// Used by the round controller and by key_expansion in the parent core.
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_ROUND_W    = 4;
    localparam int AES_KEY_W      = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } aes_ctrl_state_t;

    function automatic logic [7:0] aes_rcon(input logic [AES_ROUND_W-1:0] r);
        logic [7:0] v;
        v = 8'h00;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: latches the key, steps round 0..10 and strobes the shared datapath.
// Latency: accept at T, out_valid at T+12; back-to-back accept in DONE gives one block per 12 cycles.
// Backpressure: holds DONE while out_ready=0; optional abort (AES_CTRL_ABORT_EN) returns to IDLE.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int ROUND_W    = AES_ROUND_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_KEY_W-1:0] in_key,
    output logic [AES_KEY_W-1:0] key_q,
    output logic [ROUND_W-1:0]   round,
    output logic                 pt_capture,
    output logic                 st_load,
    output logic                 st_en,
    output logic                 last_round,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    input  logic                 abort
);

`ifdef AES_CTRL_ABORT_EN
    localparam logic ABORT_EN = 1'b1;
`else
    localparam logic ABORT_EN = 1'b0;
`endif

    aes_ctrl_state_t      r_state;
    logic [AES_KEY_W-1:0] r_key;
    logic [ROUND_W-1:0]   r_round;
    logic                 r_st_load;
    logic                 r_st_en;
    logic                 r_last;
    logic                 r_out_valid;
    logic                 r_busy;

    logic w_abort;
    logic w_in_ready;
    logic w_accept;

    assign w_abort    = abort & ABORT_EN & (r_state != ST_IDLE);
    // DONE may accept the next block in the same cycle its result is consumed.
    assign w_in_ready = ~rst & ~w_abort &
                        ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
    assign w_accept   = in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_round     <= '0;
            r_st_load   <= 1'b0;
            r_st_en     <= 1'b0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_st_load   <= 1'b0;
            r_st_en     <= 1'b0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
            if (w_abort) begin
                r_state <= ST_IDLE;
                r_round <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_key     <= in_key;
                            r_state   <= ST_LOAD;
                            r_round   <= '0;
                            r_st_load <= 1'b1;
                        end else begin
                            r_busy <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        r_state <= ST_ROUND;
                        r_round <= ROUND_W'(1);
                        r_st_en <= 1'b1;
                    end
                    ST_ROUND: begin
                        r_st_en <= 1'b1;
                        if (r_round == ROUND_W'(NUM_ROUNDS - 1)) begin
                            r_state <= ST_FINAL;
                            r_round <= ROUND_W'(NUM_ROUNDS);
                            r_last  <= 1'b1;
                        end else begin
                            r_round <= r_round + ROUND_W'(1);
                        end
                    end
                    ST_FINAL: begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                    ST_DONE: begin
                        if (w_accept) begin
                            r_key     <= in_key;
                            r_state   <= ST_LOAD;
                            r_round   <= '0;
                            r_st_load <= 1'b1;
                        end else if (out_ready) begin
                            r_state <= ST_IDLE;
                            r_round <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_round <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign pt_capture = w_accept;
    assign key_q      = r_key;
    assign round      = r_round;
    assign st_load    = r_st_load & ~w_abort;
    assign st_en      = r_st_en & ~w_abort;
    assign last_round = r_last & ~w_abort;
    assign out_valid  = r_out_valid & ~w_abort;
    assign busy       = r_busy;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomised bench for aes_round_ctrl against a cycle-offset model of one block in flight.
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] key_q;
    logic [3:0]   round;
    logic         pt_capture;
    logic         st_load;
    logic         st_en;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         abort;

`ifdef AES_CTRL_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    aes_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_key     (in_key),
        .key_q      (key_q),
        .round      (round),
        .pt_capture (pt_capture),
        .st_load    (st_load),
        .st_en      (st_en),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: k = cycles since accept (1..11 active rounds, 12 = result held), 0 = idle.
    int           k;
    logic [127:0] m_key;
    bit           m_valid;
    int           rs_prev;
    int           n_done;

    initial begin
        bit ab;
        bit exp_rdy;
        bit acc;
        int exp_round;

        k        = 0;
        m_key    = '0;
        m_valid  = 1'b0;
        rs_prev  = -1;
        n_done   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_key   = '0;
        out_ready = 1'b0;
        abort    = 1'b0;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
                rst       = (cyc < 2) || ($urandom_range(0, 199) == 0);
                in_valid  = ($urandom_range(0, 9) < 7);
                in_key    = {$urandom, $urandom, $urandom, $urandom};
                out_ready = ($urandom_range(0, 1) == 1);
                abort     = !rst && ($urandom_range(0, 39) == 0);
            end
            @(negedge clk);

            ab      = ABORT_ON && abort && (k != 0);
            exp_rdy = !rst && !ab && ((k == 0) || (k == 12 && out_ready));
            acc     = in_valid && exp_rdy;
            if (k >= 2 && k <= 11)
                exp_round = k - 1;
            else if (k == 12)
                exp_round = 10;
            else
                exp_round = 0;

            if (m_valid) begin
                check("in_ready",   128'(in_ready),   128'(exp_rdy));
                check("pt_capture", 128'(pt_capture), 128'(acc));
                check("st_load",    128'(st_load),    128'(k == 1 && !ab));
                check("st_en",      128'(st_en),      128'(k >= 2 && k <= 11 && !ab));
                check("last_round", 128'(last_round), 128'(k == 11 && !ab));
                check("out_valid",  128'(out_valid),  128'(k == 12 && !ab));
                check("busy",       128'(busy),       128'(k != 0));
                check("round",      128'(round),      128'(exp_round));
                check("key_q",      key_q,            m_key);

                // Independent monitor: rounds seen on st_en must run 1..10 after a st_load.
                if (st_load) begin
                    check("load_round", 128'(round), 128'(0));
                    rs_prev = 0;
                end
                if (st_en) begin
                    check("round_seq", 128'(round), 128'(rs_prev + 1));
                    rs_prev = round;
                end
                if (out_valid && out_ready)
                    n_done++;
            end

            if (rst) begin
                k       = 0;
                m_key   = '0;
                m_valid = 1'b1;
                rs_prev = -1;
            end else if (ab) begin
                k       = 0;
                rs_prev = -1;
            end else if (acc) begin
                m_key = in_key;
                k     = 1;
            end else if (k == 12) begin
                if (out_ready)
                    k = 0;
            end else if (k != 0) begin
                k++;
            end
        end

        check("blocks_completed", 128'(n_done > 50), 128'(1));
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer.
- Accepts one key/block request via valid/ready and latches the key for the combinational key_expansion block.
- Steps the round index 0..10 and issues load/enable/last-round strobes to the shared round datapath (state register, SubBytes/ShiftRows/MixColumns/AddRoundKey).
- Presents completion via valid/ready. One block in flight at a time.

Parameters:
- NUM_ROUNDS, 10, final round index; fixed at 10 for AES-128, other values unsupported.
- ROUND_W, 4, width of the round index bus.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  controller can accept a request
- in_key  in  128  cipher key, sampled on accept
- key_q  out  128  latched key, drives key_expansion initial_key
- round  out  ROUND_W  round index to key_expansion and datapath
- pt_capture  out  1  datapath latches plaintext this cycle
- st_load  out  1  datapath loads state = plaintext ^ round_key(0)
- st_en  out  1  datapath applies one full/final round to state
- last_round  out  1  with st_en: skip MixColumns
- out_valid  out  1  ciphertext in datapath state register is valid
- out_ready  in  1  consumer accepts ciphertext
- busy  out  1  high in any state other than IDLE
- abort  in  1  cancel in-flight operation; used only with AES_CTRL_ABORT_EN

Behaviour:
- Reset values: in_ready=0 in the reset cycle, then 1 from IDLE. key_q=0, round=0, pt_capture=0, st_load=0, st_en=0, last_round=0, out_valid=0, busy=0. FSM=IDLE.
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready (accept, cycle T):
    - key_q<=in_key; pt_capture=1 combinationally in T.
    - Next state LOAD.
  - LOAD (T+1): round=0, st_load=1. Next state ROUND with round<=1.
  - ROUND (T+2..T+10): st_en=1, last_round=0, round=1..9. round increments each cycle. When round==NUM_ROUNDS-1, next state FINAL and round<=10.
  - FINAL (T+11): round=10, st_en=1, last_round=1. Next state DONE.
  - DONE (T+12 onward): out_valid=1, held with round=10 until out_ready.
    - On out_valid&&out_ready with in_valid low: IDLE.
    - With in_valid high in the same cycle: in_ready=1 in DONE when out_ready=1; the new request is accepted (key_q updated, pt_capture=1) and the next state is LOAD (back-to-back, no IDLE bubble).
- Latency: accept at T, out_valid at T+12. Throughput: one block per 12 cycles when back-to-back.
- Strobes st_load/st_en/pt_capture are single-cycle and mutually exclusive per cycle, except pt_capture may coincide with out_valid in DONE.
- key_q is stable from T+1 until the next accept; round changes only on clk edges.
- in_key/in_valid changes while not in_ready are ignored.
- rst asserted mid-operation: next cycle is IDLE with all outputs at reset values; no out_valid for the aborted block.
- round never exceeds 10; illegal FSM encodings return to IDLE.

Optional Feature:
AES_CTRL_ABORT_EN
- Defined:
  - abort=1 in LOAD/ROUND/FINAL/DONE forces IDLE next cycle.
  - Strobes are deasserted in the abort cycle; out_valid drops.
  - key_q is retained; any pending out handshake in that cycle is not completed.
  - abort in IDLE has no effect.
  - abort has priority over out_ready and in_valid.
- Undefined: abort port present but ignored; the FSM runs to DONE unconditionally.

Decomposition:
- Shared package aes_pkg:
  - FSM state typedef (aes_ctrl_state_t).
  - AES_NUM_ROUNDS=10, AES_ROUND_W=4, AES_KEY_W=128.
  - Rcon constant table, shared with key_expansion.
- No sub-module; the round counter lives inside the FSM. key_expansion and the datapath are instantiated by the parent core, not inside this block.

Test Plan:
- Single block: in_key=000102..0f with parent core + FIPS-197 plaintext 00112233..ff.
  - st_load at T+1, st_en at T+2..T+11, last_round only at T+11, out_valid at T+12.
  - Ciphertext 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
- Output backpressure: out_ready=0 for 5 cycles after out_valid.
  - out_valid, round=10, key_q held.
  - in_ready=0; a new in_valid is ignored until out_ready=1.
- Back-to-back: in_valid held with a second key while out_ready=1 in DONE.
  - Second accept occurs in the DONE cycle; LOAD follows next cycle.
  - Second out_valid exactly 12 cycles after the first.
- Reset mid-run: rst=1 at T+6.
  - At T+7: busy=0, in_ready=1, round=0, no strobes.
  - out_valid never asserts for that block.
- Round sequence check: monitor round during st_en pulses; required sequence is 1,2,...,10 with no repeats or gaps. round=0 only with st_load.
- AES_CTRL_ABORT_EN: abort=1 at T+4.
  - IDLE at T+5, out_valid never set.
  - Without the macro, the same stimulus completes with out_valid at T+12.
